// File: rtl/alu_sequencer_if.sv
// Command, register-file, ALU and status signals shared between the host side
// and the alu_sequencer.
interface alu_sequencer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int REG_BIT_CNT = 3,
  parameter int CNTR_WIDTH  = 4
);
  logic                   op_valid;
  logic                   op_ready;
  logic [ADDR_WIDTH-1:0]  op_code;
  logic                   op_imm_sel;
  logic [DATA_WIDTH-1:0]  op_imm;
  logic [REG_BIT_CNT-1:0] op_reg;
  logic [CNTR_WIDTH-1:0]  op_rep;
  logic                   abort;

  logic                   reg_we;
  logic [REG_BIT_CNT-1:0] reg_waddr;
  logic [DATA_WIDTH-1:0]  reg_wdata;

  logic [ADDR_WIDTH-1:0]  alu_op;
  logic [DATA_WIDTH-1:0]  alu_in1;
  logic [DATA_WIDTH-1:0]  alu_in2;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   alu_zero;
  logic                   alu_ls;
  logic                   alu_gr;

  logic [DATA_WIDTH-1:0]  acc;
  logic [2:0]             flags;
  logic                   busy;
  logic                   done;

  modport master (
    output op_valid, op_code, op_imm_sel, op_imm, op_reg, op_rep, abort,
           reg_we, reg_waddr, reg_wdata, alu_res, alu_zero, alu_ls, alu_gr,
    input  op_ready, alu_op, alu_in1, alu_in2, acc, flags, busy, done
  );

  modport slave (
    input  op_valid, op_code, op_imm_sel, op_imm, op_reg, op_rep, abort,
           reg_we, reg_waddr, reg_wdata, alu_res, alu_zero, alu_ls, alu_gr,
    output op_ready, alu_op, alu_in1, alu_in2, acc, flags, busy, done
  );
endinterface

// File: rtl/alu_sequencer.sv
// Repeats one ALU operation N times on an accumulator, with operand B taken
// from an immediate or an internal register file sampled at command accept.
module alu_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int REG_BIT_CNT = 3,
  parameter int CNTR_WIDTH  = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_sequencer_if.slave bus
);
  localparam int unsigned NREGS = 2 ** REG_BIT_CNT;
  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  rf_q [NREGS];
  logic [DATA_WIDTH-1:0]  acc_q;
  logic [2:0]             flags_q;
  logic [CNTR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  op_q;
  logic [DATA_WIDTH-1:0]  opb_q, opb_d;
  logic                   ready_q;
  logic                   busy_q;
  logic                   done_q;

  // rf_q read here is the pre-edge value, so a same-cycle write is not seen.
  always_comb begin
    opb_d = bus.op_imm_sel ? bus.op_imm : rf_q[bus.op_reg];
    cnt_d = (bus.op_rep == '0) ? CNT_ONE : bus.op_rep;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rf_q    <= '{default: '0};
      acc_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      opb_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (bus.reg_we) rf_q[bus.reg_waddr] <= bus.reg_wdata;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.op_valid) begin
            op_q    <= bus.op_code;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            state_q <= S_EXEC;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_EXEC: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            opb_q   <= '0;
          end else begin
            acc_q   <= bus.alu_res;
            flags_q <= {bus.alu_gr, bus.alu_ls, bus.alu_zero};
            if (cnt_q == CNT_ONE) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= '0;
              op_q    <= '0;
              opb_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // op_q/opb_q are held at zero outside EXEC, so the ALU sees idle values.
  assign bus.op_ready = ready_q;
  assign bus.alu_op   = op_q;
  assign bus.alu_in1  = acc_q;
  assign bus.alu_in2  = opb_q;
  assign bus.acc      = acc_q;
  assign bus.flags    = flags_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, ALU operand/result width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, ALU opcode width.
REQ-003 SHALL have parameter REG_BIT_CNT, default 3, register-file index width (2^REG_BIT_CNT entries).
REQ-004 SHALL have parameter CNTR_WIDTH, default 4, repeat-counter width.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 op_valid  in  1  command request.
REQ-009 op_ready  out  1  sequencer can accept a command.
REQ-010 op_code  in  ADDR_WIDTH  ALU operation for the command.
REQ-011 op_imm_sel  in  1  1 = operand B from op_imm, 0 = from register file.
REQ-012 op_imm  in  DATA_WIDTH  immediate operand.
REQ-013 op_reg  in  REG_BIT_CNT  register index for operand B.
REQ-014 op_rep  in  CNTR_WIDTH  iteration count; 0 means 1.
REQ-015 abort  in  1  cancel the running command.
REQ-016 reg_we / reg_waddr / reg_wdata  in  1 / REG_BIT_CNT / DATA_WIDTH  register-file write port.
REQ-017 alu_op  out  ADDR_WIDTH  opcode driven to the ALU.
REQ-018 alu_in1 / alu_in2  out  DATA_WIDTH each  accumulator / operand B driven to the ALU.
REQ-019 alu_res  in  DATA_WIDTH  ALU combinational result.
REQ-020 alu_zero / alu_ls / alu_gr  in  1 each  ALU zero, less-than-zero, greater-than-zero flags.
REQ-021 acc  out  DATA_WIDTH  accumulator register.
REQ-022 flags  out  3  registered {gr, ls, zero} from the final iteration.
REQ-023 busy  out  1  high in EXEC state.
REQ-024 done  out  1  one-cycle pulse on command completion.

Function
REQ-025 FSM SHALL have states IDLE, EXEC, DONE; op_ready = 1 only in IDLE.
REQ-026 IDLE: on op_valid & op_ready SHALL latch op_code, operand B, and count = max(op_rep,1), then go to EXEC.
REQ-027 Operand B SHALL be sampled at accept; a same-cycle reg_we to op_reg SHALL NOT affect it (old value used).
REQ-028 EXEC: alu_op = latched opcode, alu_in1 = acc, alu_in2 = latched operand B; each cycle acc <= alu_res, flags <= {alu_gr, alu_ls, alu_zero}, count decrements.
REQ-029 EXEC with count == 1 SHALL perform the final update and go to DONE; N iterations take exactly N EXEC cycles.
REQ-030 DONE: done = 1 for one cycle, then IDLE; latency accept-edge to done = N+1 cycles.
REQ-031 Outside EXEC alu_op SHALL be all-zero, and alu_in1 = acc, alu_in2 = 0.
REQ-032 abort in EXEC SHALL return to IDLE next edge with no acc/flags update that cycle and no done pulse; abort in IDLE/DONE SHALL be ignored.
REQ-033 op_valid while not ready SHALL be ignored (no queuing).
REQ-034 Register file SHALL write on reg_we in any state; writes to other registers during EXEC SHALL NOT affect the running command.
REQ-035 All arithmetic SHALL be in the ALU; the count SHALL never wrap (op_rep max = 2^CNTR_WIDTH-1 iterations).

Reset
REQ-036 rst_n = 0 at a clock edge SHALL force IDLE, acc = 0, flags = 3'b000, done = 0, busy = 0, count = 0, and all register-file entries = 0.
REQ-037 Reset mid-EXEC SHALL abandon the command without a done pulse; op_ready = 1 the first cycle after rst_n rises.

Verification
REQ-038 Reset, then check acc = 0x00, flags = 000, op_ready = 1, busy = 0, done = 0.
REQ-039 Write r2 = 0x03; LDi imm 0x05 rep 0 -> done 2 cycles after accept, acc = 0x05, flags = 100; then ADDr r2 rep 3 -> busy 3 cycles, acc = 0x0E, done at accept+4.
REQ-040 acc = 0x01, SUBi imm 0x01 rep 2 -> acc = 0xFF, flags = 010; reissue with rep 1 from acc = 0x01 -> acc = 0x00, flags = 001.
REQ-041 Start INC rep 10 from 0x00, assert abort in 4th EXEC cycle -> acc = 0x03, no done pulse, op_ready = 1 next cycle.
REQ-042 Same-cycle accept of ADDr r1 and reg_we r1 = 0x20 (r1 was 0x01), acc = 0x00, rep 1 -> acc = 0x01; op_valid held during EXEC is not accepted.
REQ-043 rst_n low during EXEC of a rep-5 command -> next cycle IDLE, acc = 0x00, r-file cleared, no done.
